ifu_fetch_ctrl: RTL
===================

Name: ifu_fetch_ctrl

Overview:
Instruction-fetch controller upstream of the decode stage. It owns the PC and issues one outstanding request at a time to the instruction memory port. It buffers the returned 32-bit instruction and presents it to decode with a valid/ready handshake. It also accepts PC redirects (branch/jump) from execute and discards any in-flight fetch that a redirect makes stale.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- rst, input, 1, asynchronous active-low reset (0 = reset asserted).
- req_valid, output, 1, imem request valid.
- req_ready, input, 1, imem accepts request this cycle.
- req_addr, output, 64, imem request address; equals current PC.
- resp_valid, input, 1, imem returns data this cycle; single-cycle pulse, no backpressure.
- resp_data, input, 32, returned instruction word.
- inst_valid, output, 1, instruction buffer holds a valid instruction for decode.
- inst_ready, input, 1, decode accepts the instruction.
- inst, output, 32, buffered instruction.
- inst_pc, output, 64, PC of the buffered instruction.
- redirect_valid, input, 1, execute requests a PC change.
- redirect_pc, input, 64, new PC; bits [1:0] ignored and treated as 0.
- fetch_cnt, output, 64, count of instructions delivered to decode.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=REQ, inst=0, inst_pc=0, inst_valid=0, fetch_cnt=0.
- Outputs:
  - req_valid = (state==REQ), combinational from state.
  - req_addr = pc.
  - inst_valid = (state==HOLD), registered.
- Handshakes:
  - Request fires when req_valid & req_ready.
  - Deliver fires when inst_valid & inst_ready.
  - req_valid is held with a stable req_addr until it fires or a redirect occurs.
- States: REQ, WAIT, HOLD, DROP.
- REQ:
  - Fire, no redirect -> WAIT.
  - redirect_valid, no fire -> pc<=redirect_pc; stay REQ.
  - redirect_valid and fire together -> pc<=redirect_pc -> DROP. The issued request is stale.
- WAIT:
  - resp_valid, no redirect -> inst<=resp_data, inst_pc<=pc -> HOLD.
  - redirect_valid and resp_valid together -> discard data, pc<=redirect_pc -> REQ.
  - redirect_valid alone -> pc<=redirect_pc -> DROP.
- DROP:
  - resp_valid -> discard data -> REQ.
  - redirect_valid in DROP -> pc<=redirect_pc; stay DROP until the pending response returns. Latest redirect wins.
- HOLD:
  - inst, inst_pc and inst_valid are stable until deliver fires or a redirect occurs.
  - Deliver fires, no redirect -> pc<=pc+4, fetch_cnt+=1 -> REQ.
  - redirect_valid alone -> pc<=redirect_pc -> REQ. Instruction squashed; fetch_cnt unchanged.
  - redirect_valid and deliver together -> instruction counts as delivered, fetch_cnt+=1, pc<=redirect_pc (not pc+4) -> REQ.
- Latency:
  - Earliest req_valid is the first cycle after reset deasserts.
  - Request fire to inst_valid is (imem latency + 1) cycles.
  - Back-to-back throughput is at most 1 instruction per 3 cycles with a 1-cycle imem.
- Arithmetic:
  - pc+4 is a 64-bit add that wraps modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC -> 0).
  - fetch_cnt wraps modulo 2^64.
- At most one request outstanding. A resp_valid in REQ or HOLD is a protocol violation and is ignored (the bench asserts this never occurs).
- Reset mid-operation: asynchronous return to reset values. Any imem response after reset release and before the first new fire is ignored; the state is REQ, where responses are ignored.

Test Plan:
1. Reset release, imem 1-cycle latency, decode always ready, resp_data=0x00000013 -> req_addr sequence 0x80000000, 0x80000004, 0x80000008; inst_pc matches each; fetch_cnt=3 after three deliveries.
2. Decode backpressure: inst_ready=0 for 5 cycles in HOLD -> inst_valid, inst and inst_pc stable; no new req_valid; on inst_ready=1, next req_addr = inst_pc+4.
3. Redirect during WAIT (imem latency 3, redirect_pc=0x80001002) -> stale response discarded; inst_valid stays 0; next req_addr=0x80001000; fetch_cnt unchanged.
4. Redirect coincident with deliver in HOLD (redirect_pc=0x80000100) -> fetch_cnt increments by 1; next req_addr=0x80000100, not pc+4.
5. Redirect coincident with request fire, then a second redirect in DROP (0x80000200, then 0x80000300) -> one response dropped; next req_addr=0x80000300.
6. Async reset asserted mid-WAIT with the response arriving 1 cycle after release -> all outputs return to reset values immediately; the late response is ignored; req_addr=0x80000000 on release.

Source files
------------

// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch-controller bus bundle: imem request/response, decode handoff, execute redirect, delivery count.
// master = the fetch controller, slave = the surrounding imem/decode/execute environment.
interface ifu_fetch_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] fetch_cnt;

  modport master (
    output req_valid, req_addr, inst_valid, inst, inst_pc, fetch_cnt,
    input  req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_addr, inst_valid, inst, inst_pc, fetch_cnt,
    output req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Single-outstanding instruction fetch controller; fire->inst_valid is imem latency + 1 cycles.
// Decode backpressure holds the buffer and blocks new requests; redirects squash or drop stale fetches.
module ifu_fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input logic              clk,
  input logic              rst,
  ifu_fetch_ctrl_if.master bus
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  logic [1:0]  state;
  logic [63:0] pc;
  logic [31:0] inst_q;
  logic [63:0] inst_pc_q;
  logic [63:0] fetch_cnt_q;

  logic        req_fire;
  logic        deliver;
  logic [63:0] redirect_tgt;

  // Instructions are word aligned; the low address bits of a redirect are dropped.
  assign redirect_tgt = bus.redirect_pc & ~64'd3;

  assign req_fire = (state == ST_REQ) && bus.req_ready;
  assign deliver  = (state == ST_HOLD) && bus.inst_ready;

  assign bus.req_valid  = (state == ST_REQ);
  assign bus.req_addr   = pc;
  assign bus.inst_valid = (state == ST_HOLD);
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.fetch_cnt  = fetch_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_REQ;
      pc          <= RESET_PC;
      inst_q      <= 32'd0;
      inst_pc_q   <= 64'd0;
      fetch_cnt_q <= 64'd0;
    end else begin
      case (state)
        ST_REQ: begin
          // A redirect in the same cycle as the fire leaves a stale request in flight.
          if (bus.redirect_valid) begin
            pc <= redirect_tgt;
            if (req_fire) state <= ST_DROP;
          end else if (req_fire) begin
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (bus.redirect_valid) begin
            pc    <= redirect_tgt;
            state <= bus.resp_valid ? ST_REQ : ST_DROP;
          end else if (bus.resp_valid) begin
            inst_q    <= bus.resp_data;
            inst_pc_q <= pc;
            state     <= ST_HOLD;
          end
        end

        ST_DROP: begin
          if (bus.redirect_valid) pc <= redirect_tgt;
          if (bus.resp_valid) state <= ST_REQ;
        end

        ST_HOLD: begin
          // A deliver coincident with a redirect still counts; the redirect target wins over pc+4.
          if (deliver) fetch_cnt_q <= fetch_cnt_q + 64'd1;
          if (bus.redirect_valid) begin
            pc    <= redirect_tgt;
            state <= ST_REQ;
          end else if (deliver) begin
            pc    <= pc + 64'd4;
            state <= ST_REQ;
          end
        end

        default: state <= ST_REQ;
      endcase
    end
  end

endmodule
